tone_player: RTL

Plays short fixed jingles (game start, left-player win, right-player win, tie) on a single-bit speaker pin. It sits directly downstream of the 1/256 clock-enable divider and consumes its `slowen` strobe as the only time base. The game FSM triggers it with a one-cycle `play` pulse plus a song select. All pitch and duration counting advances only on `slowen` cycles.

---
 rtl/tone_player_pkg.sv | 47 ++++
 rtl/tone_player_if.sv | 10 +
 rtl/tone_player_rom.sv | 10 +
 rtl/tone_player.sv | 106 ++++++++++
 4 files changed

// File: rtl/tone_player_pkg.sv
// tone_pkg: FSM encoding, ROM entry layout and jingle contents shared by the tone player.
package tone_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_e;
  localparam int HP_W = 8;
  localparam int DUR_W = 4;
  localparam int DUR_CNT_W = 5;
  localparam int PRE_W = 12;
  localparam int GAP_W = 10;
  localparam logic [1:0] SONG_START = 2'd0;
  localparam logic [1:0] SONG_LEFT = 2'd1;
  localparam logic [1:0] SONG_RIGHT = 2'd2;
  localparam logic [1:0] SONG_TIE = 2'd3;
  typedef struct packed {
    logic             last;
    logic [DUR_W-1:0] dur;
    logic [HP_W-1:0]  hp;
  } rom_entry_t;
  function automatic rom_entry_t note(input logic last, input logic [DUR_W-1:0] dur, input logic [HP_W-1:0] hp);
    return '{last: last, dur: dur, hp: hp};
  endfunction
  // hp=0 is a rest, dur=0 means 16 units; unlisted slots are never reached
  function automatic rom_entry_t rom_lookup(input logic [4:0] addr);
    rom_entry_t e;
    e = '0;
    case (addr)
      {SONG_START, 3'd0}: e = note(1'b0, 4'd4, 8'd222);
      {SONG_START, 3'd1}: e = note(1'b0, 4'd4, 8'd180);
      {SONG_START, 3'd2}: e = note(1'b0, 4'd2, 8'd150);
      {SONG_START, 3'd3}: e = note(1'b1, 4'd8, 8'd111);
      {SONG_LEFT, 3'd0}:  e = note(1'b0, 4'd2, 8'd10);
      {SONG_LEFT, 3'd1}:  e = note(1'b0, 4'd0, 8'd0);
      {SONG_LEFT, 3'd2}:  e = note(1'b1, 4'd3, 8'd16);
      {SONG_RIGHT, 3'd0}: e = note(1'b0, 4'd1, 8'd5);
      {SONG_RIGHT, 3'd1}: e = note(1'b0, 4'd1, 8'd6);
      {SONG_RIGHT, 3'd2}: e = note(1'b0, 4'd1, 8'd7);
      {SONG_RIGHT, 3'd3}: e = note(1'b0, 4'd1, 8'd8);
      {SONG_RIGHT, 3'd4}: e = note(1'b0, 4'd1, 8'd9);
      {SONG_RIGHT, 3'd5}: e = note(1'b0, 4'd1, 8'd10);
      {SONG_RIGHT, 3'd6}: e = note(1'b0, 4'd1, 8'd11);
      {SONG_RIGHT, 3'd7}: e = note(1'b0, 4'd1, 8'd12);
      {SONG_TIE, 3'd0}:   e = note(1'b0, 4'd1, 8'd3);
      {SONG_TIE, 3'd1}:   e = note(1'b1, 4'd1, 8'd0);
      default:            e = '0;
    endcase
    return e;
  endfunction
endpackage

// File: rtl/tone_player_if.sv
// tone_player_if: trigger and status bundle between the game FSM and the tone player.
interface tone_player_if;
  logic       play;
  logic [1:0] song_sel;
  logic       speaker;
  logic       busy;
  logic       done;
  modport master (output play, song_sel, input speaker, busy, done);
  modport slave (input play, song_sel, output speaker, busy, done);
endinterface

// File: rtl/tone_player_rom.sv
// tone_rom: combinational 32x13 jingle lookup addressed by {song, idx}.
module tone_rom
  import tone_pkg::*;
(
  input  logic [1:0] i_song,
  input  logic [2:0] i_idx,
  output rom_entry_t o_entry
);
  assign o_entry = rom_lookup({i_song, i_idx});
endmodule

// File: rtl/tone_player.sv
// tone_player: plays ROM jingles on a square-wave speaker pin, timed only by slowen.
module tone_player
  import tone_pkg::*;
#(
  parameter int DUR_UNIT = 4096,
  parameter int GAP_TICKS = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic slowen,
  tone_player_if.slave bus
);
  state_e               r_state, w_state_nx;
  logic [1:0]           r_song, w_song_nx;
  logic [2:0]           r_idx, w_idx_nx;
  logic [PRE_W-1:0]     r_pre, w_pre_nx;
  logic [GAP_W-1:0]     r_gap, w_gap_nx;
  logic [HP_W-1:0]      r_hp, w_hp_nx;
  logic [DUR_CNT_W-1:0] r_dur, w_dur_nx;
  logic                 r_speaker, w_speaker_nx;
  rom_entry_t           w_entry;
  logic                 w_unit_wrap;
  logic                 w_hp_hit;
  logic                 w_song_end;

  tone_rom u_rom (
    .i_song (r_song),
    .i_idx  (r_idx),
    .o_entry(w_entry)
  );

  assign w_unit_wrap = r_pre == PRE_W'(DUR_UNIT - 1);
  assign w_hp_hit = r_hp <= 8'd1;
  assign w_song_end = w_entry.last || r_idx == 3'd7;
  assign bus.speaker = r_speaker;
  assign bus.busy = r_state != S_IDLE;
  assign bus.done = r_state == S_DONE;

  always_comb begin
    w_state_nx = r_state;
    w_song_nx = r_song;
    w_idx_nx = r_idx;
    w_pre_nx = r_pre;
    w_gap_nx = r_gap;
    w_hp_nx = r_hp;
    w_dur_nx = r_dur;
    w_speaker_nx = r_speaker;
    case (r_state)
      S_IDLE: if (bus.play) begin
        w_state_nx = S_LOAD;
        w_song_nx = bus.song_sel;
        w_idx_nx = '0;
      end
      S_LOAD: begin
        w_hp_nx = w_entry.hp;
        w_pre_nx = '0;
        w_dur_nx = (w_entry.dur == '0) ? DUR_CNT_W'(16) : DUR_CNT_W'(w_entry.dur);
        w_speaker_nx = 1'b0;
        w_state_nx = S_PLAY;
      end
      S_PLAY: if (slowen) begin
        w_hp_nx = w_hp_hit ? w_entry.hp : r_hp - 1'b1;
        w_speaker_nx = r_speaker ^ (w_hp_hit && w_entry.hp != '0);
        w_pre_nx = w_unit_wrap ? '0 : r_pre + 1'b1;
        w_dur_nx = w_unit_wrap ? r_dur - 1'b1 : r_dur;
        // end of note overrides a toggle landing on the same tick
        if (w_unit_wrap && r_dur == 5'd1) begin
          w_speaker_nx = 1'b0;
          w_gap_nx = GAP_W'(GAP_TICKS);
          w_state_nx = S_GAP;
        end
      end
      S_GAP: if (slowen) begin
        w_gap_nx = r_gap - 1'b1;
        if (r_gap == 10'd1) begin
          w_state_nx = w_song_end ? S_DONE : S_LOAD;
          w_idx_nx = w_song_end ? r_idx : r_idx + 1'b1;
        end
      end
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_song <= '0;
      r_idx <= '0;
      r_pre <= '0;
      r_gap <= '0;
      r_hp <= '0;
      r_dur <= '0;
      r_speaker <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_song <= w_song_nx;
      r_idx <= w_idx_nx;
      r_pre <= w_pre_nx;
      r_gap <= w_gap_nx;
      r_hp <= w_hp_nx;
      r_dur <= w_dur_nx;
      r_speaker <= w_speaker_nx;
    end
  end
endmodule
